// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA timing master with registered sync, coordinates and strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] C_H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_H_FP_START = 10'(H_DISPLAY);
    localparam logic [9:0] C_H_SY_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] C_H_BP_START = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] C_V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_V_FP_START = 10'(V_DISPLAY);
    localparam logic [9:0] C_V_SY_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] C_V_BP_START = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    phase_t     h_state_q, h_state_d;
    phase_t     v_state_q, v_state_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_start_q, vblank_start_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_line_wrap;

    // Position the counters move to on an enabled edge.
    always_comb begin
        w_line_wrap = (hpos_q == C_H_MAX);
        w_h_next    = w_line_wrap ? 10'd0 : hpos_q + 10'd1;
        w_v_next    = vpos_q;
        if (w_line_wrap) begin
            w_v_next = (vpos_q == C_V_MAX) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    always_comb begin
        h_state_d = h_state_q;
        if (ena) begin
            case (h_state_q)
                PH_ACTIVE: if (w_h_next == C_H_FP_START) h_state_d = PH_FRONT;
                PH_FRONT:  if (w_h_next == C_H_SY_START) h_state_d = PH_SYNC;
                PH_SYNC:   if (w_h_next == C_H_BP_START) h_state_d = PH_BACK;
                PH_BACK:   if (w_h_next == 10'd0)        h_state_d = PH_ACTIVE;
                default:                                 h_state_d = PH_BACK;
            endcase
        end
    end

    always_comb begin
        v_state_d = v_state_q;
        if (ena && w_line_wrap) begin
            case (v_state_q)
                PH_ACTIVE: if (w_v_next == C_V_FP_START) v_state_d = PH_FRONT;
                PH_FRONT:  if (w_v_next == C_V_SY_START) v_state_d = PH_SYNC;
                PH_SYNC:   if (w_v_next == C_V_BP_START) v_state_d = PH_BACK;
                PH_BACK:   if (w_v_next == 10'd0)        v_state_d = PH_ACTIVE;
                default:                                 v_state_d = PH_BACK;
            endcase
        end
    end

    // Outputs are derived from the next state so they line up with the
    // coordinates registered on the same edge.
    always_comb begin
        hpos_d         = hpos_q;
        vpos_d         = vpos_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        display_on_d   = display_on_q;
        frame_count_d  = frame_count_q;
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;
        if (ena) begin
            hpos_d         = w_h_next;
            vpos_d         = w_v_next;
            hsync_d        = (h_state_d == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d        = (v_state_d == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            display_on_d   = (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
            line_start_d   = (w_h_next == 10'd0);
            frame_start_d  = (w_h_next == 10'd0) && (w_v_next == 10'd0);
            vblank_start_d = (w_h_next == 10'd0) && (w_v_next == C_V_FP_START);
            if (frame_start_d) begin
                frame_count_d = frame_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_state_q      <= PH_BACK;
            v_state_q      <= PH_BACK;
            hpos_q         <= C_H_MAX;
            vpos_q         <= C_V_MAX;
            hsync_q        <= ~SYNC_ACTIVE;
            vsync_q        <= ~SYNC_ACTIVE;
            display_on_q   <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            frame_count_q  <= 8'hFF;
        end else begin
            h_state_q      <= h_state_d;
            v_state_q      <= v_state_d;
            hpos_q         <= hpos_d;
            vpos_q         <= vpos_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            display_on_q   <= display_on_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_on   = display_on_q;
    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign frame_count  = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Directed bench: default 640x480 timing plus a tiny 16x12 timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b1;

    always #5 clk = ~clk;

    // Default timing instance
    logic       d_hsync, d_vsync, d_display_on, d_line_start, d_frame_start, d_vblank_start;
    logic [9:0] d_hpos, d_vpos;
    logic [7:0] d_frame_count;

    vga_sync_gen u_dut_def (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(d_hsync), .vsync(d_vsync), .display_on(d_display_on),
        .hpos(d_hpos), .vpos(d_vpos),
        .line_start(d_line_start), .frame_start(d_frame_start),
        .vblank_start(d_vblank_start), .frame_count(d_frame_count)
    );

    // Small timing: H 8/2/3/3 (total 16), V 6/2/2/2 (total 12), 192 cycles per frame
    logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start, s_vblank_start;
    logic [9:0] s_hpos, s_vpos;
    logic [7:0] s_frame_count;

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b0)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(s_hsync), .vsync(s_vsync), .display_on(s_display_on),
        .hpos(s_hpos), .vpos(s_vpos),
        .line_start(s_line_start), .frame_start(s_frame_start),
        .vblank_start(s_vblank_start), .frame_count(s_frame_count)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_ls = 0, n_fs = 0, n_vb = 0;
    int eh = 15, ev = 11;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and track the small timing.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ena) begin
            if (eh == 15) begin
                eh = 0;
                ev = (ev == 11) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
        end
        if (s_line_start)   n_ls++;
        if (s_frame_start)  n_fs++;
        if (s_vblank_start) n_vb++;
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        eh = 15; ev = 11;
        n_ls = 0; n_fs = 0; n_vb = 0;
        #1;
    endtask

    int  hs_cnt, hs_first, hs_last, de_cnt, de_last, ls_extra;
    logic hpos_ok, hold_ok;

    initial begin
        // ---------------- reset and first edge, default timing ----------------
        ena = 1'b1;
        do_reset();
        check("rst_hpos",  d_hpos, 799);
        check("rst_vpos",  d_vpos, 524);
        check("rst_hsync", d_hsync, 1);
        check("rst_vsync", d_vsync, 1);
        check("rst_de",    d_display_on, 0);
        check("rst_fc",    d_frame_count, 255);
        check("rst_strb",  {d_line_start, d_frame_start, d_vblank_start}, 0);
        check("rst_s_pos", {s_hpos, s_vpos}, {10'd15, 10'd11});

        tick();
        check("e1_pos", {d_hpos, d_vpos}, 0);
        check("e1_de",  d_display_on, 1);
        check("e1_ls",  d_line_start, 1);
        check("e1_fs",  d_frame_start, 1);
        check("e1_fc",  d_frame_count, 0);
        tick();
        check("e2_strb", {d_line_start, d_frame_start}, 0);

        // ---------------- one full default line ----------------
        hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; de_last = -1; ls_extra = 0;
        hpos_ok = 1'b1;
        for (int i = 1; i < 800; i++) begin
            if (i > 1) tick();
            if (d_hpos != 10'(i) || d_vpos != 10'd0) hpos_ok = 1'b0;
            if (!d_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_display_on) begin
                de_cnt++;
                de_last = i;
            end
            if (d_line_start) ls_extra++;
        end
        check("line_hpos_seq", hpos_ok, 1);
        check("hs_cnt",   hs_cnt, 96);
        check("hs_first", hs_first, 656);
        check("hs_last",  hs_last, 751);
        check("de_cnt",   de_cnt, 639);
        check("de_last",  de_last, 639);
        check("ls_mid",   ls_extra, 0);
        tick();
        check("wrap_pos", {d_hpos, d_vpos}, {10'd0, 10'd1});
        check("wrap_ls",  d_line_start, 1);
        check("wrap_fs",  d_frame_start, 0);

        // ---------------- small timing: frame structure ----------------
        do_reset();
        tick();                                   // (0,0)
        check("s_e1", {s_hpos, s_vpos, s_frame_count}, {10'd0, 10'd0, 8'd0});
        adv(7);  check("s_de_7",  s_display_on, 1);
        adv(1);  check("s_de_8",  s_display_on, 0);
        adv(1);  check("s_hs_9",  s_hsync, 1);
        adv(1);  check("s_hs_10", s_hsync, 0);
        adv(2);  check("s_hs_12", s_hsync, 0);
        adv(1);  check("s_hs_13", s_hsync, 1);
        adv(83);                                  // (0,6)
        check("s_vb_pos", {s_hpos, s_vpos}, {10'(eh), 10'(ev)});
        check("s_vb",     {s_vblank_start, s_line_start, s_frame_start, s_display_on}, 4'b1100);
        adv(1);  check("s_vb_off", s_vblank_start, 0);
        adv(31); check("s_vs_8",  {s_vpos, s_vsync}, {10'd8, 1'b0});
        adv(31); check("s_vs_15_9", {s_hpos, s_vpos, s_vsync}, {10'd15, 10'd9, 1'b0});
        adv(1);  check("s_vs_10", {s_hpos, s_vpos, s_vsync}, {10'd0, 10'd10, 1'b1});
        adv(415);                                 // (15,11) of third frame
        check("s_3f_pos", {s_hpos, s_vpos}, {10'd15, 10'd11});
        check("s_3f_fs",  n_fs, 3);
        check("s_3f_ls",  n_ls, 36);
        check("s_3f_vb",  n_vb, 3);
        check("s_3f_fc",  s_frame_count, 2);
        adv(1);
        check("s_4f_fc", {s_frame_count, s_frame_start}, {8'd3, 1'b1});

        // ---------------- enable hold ----------------
        adv(15);                                  // (15,0)
        ena = 1'b0;
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_hpos != 10'd15 || s_vpos != 10'd0 || s_hsync != 1'b1 || s_display_on != 1'b0 ||
                s_frame_count != 8'd3 || s_line_start || s_frame_start || s_vblank_start)
                hold_ok = 1'b0;
        end
        check("hold_frozen", hold_ok, 1);
        ena = 1'b1;
        tick();
        check("hold_rel", {s_hpos, s_vpos, s_line_start, s_frame_start}, {10'd0, 10'd1, 1'b1, 1'b0});
        ena = 1'b0;
        tick();
        check("hold_strb", {s_hpos, s_vpos, s_line_start}, {10'd0, 10'd1, 1'b0});
        ena = 1'b1;
        tick();
        check("no_repeat", {s_hpos, s_vpos, s_line_start}, {10'd1, 10'd1, 1'b0});

        // ---------------- asynchronous reset mid-frame ----------------
        adv(36);                                  // (5,3)
        check("pre_arst", {s_hpos, s_vpos}, {10'd5, 10'd3});
        #2 rst_n = 1'b0;
        #1;
        check("arst_s_pos", {s_hpos, s_vpos}, {10'd15, 10'd11});
        check("arst_s_de",  s_display_on, 0);
        check("arst_s_fc",  s_frame_count, 255);
        check("arst_d_pos", {d_hpos, d_vpos}, {10'd799, 10'd524});
        check("arst_d_misc", {d_hsync, d_vsync, d_display_on, d_frame_count}, {1'b1, 1'b1, 1'b0, 8'hFF});
        #2 rst_n = 1'b1;
        eh = 15; ev = 11;
        tick();
        check("arst_rel_s", {s_hpos, s_vpos, s_frame_start, s_frame_count}, {10'd0, 10'd0, 1'b1, 8'd0});
        check("arst_rel_d", {d_hpos, d_vpos}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing master for the VGA display path. Generates hsync/vsync, display_on and the pixel coordinates consumed by the Game of Life renderer and TinyVGA PMOD mapping.
- Adds single-cycle line/frame/vblank strobes and a frame counter. The simulation controller uses these to start board updates cleanly inside vertical blanking.
- Horizontal and vertical sequencing are explicit phase FSMs (ACTIVE, FRONT, SYNC, BACK).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  advance enable; when low, timing freezes
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- display_on  out  1  high when (hpos, vpos) is inside the visible area
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse on the cycle hpos becomes 0
- frame_start  out  1  one-cycle pulse on the cycle (hpos, vpos) becomes (0, 0)
- vblank_start  out  1  one-cycle pulse on the cycle (hpos, vpos) becomes (0, V_DISPLAY)
- frame_count  out  8  frames started, mod 256

Behaviour:
- H_TOTAL = sum of the H_* parameters (800 by default). V_TOTAL = sum of the V_* parameters (525 by default). Both must be ≤1024; counters are 10 bits and never exceed TOTAL-1.
- All outputs are registered and mutually coherent. hsync, vsync, display_on and the strobes describe the (hpos, vpos) presented in the same cycle. No output is a combinational function of ports.
- Reset (rst_n low, asynchronous): hpos = H_TOTAL-1, vpos = V_TOTAL-1, H FSM = BACK, V FSM = BACK, hsync = vsync = ~SYNC_ACTIVE, display_on = 0, all strobes = 0, frame_count = 8'hFF.
- Advance (rising clk, ena = 1):
  - hpos increments. At H_TOTAL-1 it wraps to 0 and vpos advances.
  - vpos increments on line wrap. At V_TOTAL-1 it wraps to 0.
- H FSM, driven by the next hpos:
  - ACTIVE: 0..H_DISPLAY-1
  - FRONT: H_DISPLAY..H_DISPLAY+H_FRONT-1
  - SYNC: next H_SYNC pixels
  - BACK: remainder
  - Transitions occur only on these boundaries.
- V FSM: same pattern on vpos with the V_* parameters. Transitions only on line wrap.
- hsync = SYNC_ACTIVE iff H FSM = SYNC. vsync = SYNC_ACTIVE iff V FSM = SYNC.
- display_on = (H FSM = ACTIVE) and (V FSM = ACTIVE).
- Default windows:
  - hsync asserted for hpos 656..751.
  - vsync asserted for vpos 490..491 (all columns of those lines).
  - display_on for hpos < 640 and vpos < 480.
- Strobes:
  - line_start = 1 for exactly the cycle hpos = 0 is first presented.
  - frame_start = 1 for exactly the cycle (0, 0) is first presented. It coincides with line_start.
  - vblank_start is defined the same way for (0, V_DISPLAY).
- frame_count increments (wrapping 255 → 0) on the same edge that raises frame_start.
- The first enabled edge after reset presents (0, 0) with display_on = 1 and line_start = frame_start = 1, and frame_count goes to 0.
- ena = 0: counters, FSMs, hsync, vsync, display_on and frame_count hold. All strobes are driven 0. When ena rises again, advance resumes from the held position. A strobe is never repeated for the same position.
- Reset asserted mid-line or mid-frame returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset then release with ena = 1 → before the first edge: hpos = 799, vpos = 524, hsync = vsync = 1, display_on = 0, frame_count = 255. After the first edge: (0, 0), display_on = 1, line_start = frame_start = 1, frame_count = 0. Next edge: both strobes are 0.
- Run one line on vpos = 0 → display_on falls when hpos goes 639→640. hsync = 0 exactly for hpos 656..751. At 799→0: vpos = 1 and line_start = 1.
- Run to vpos = 480 → vblank_start pulses once at (0, 480) and display_on stays 0. vsync = 0 for all of lines 490 and 491 and returns to 1 at (0, 492).
- Run 3 full frames (3 × 420000 cycles) → frame_count = 2, exactly 3 frame_start pulses, exactly 1575 line_start pulses.
- Hold ena = 0 for 10 cycles at (799, 0), then release → outputs frozen and strobes 0 during the hold. First enabled edge gives (0, 1) with line_start = 1 and frame_start = 0.
- Drop rst_n asynchronously at (300, 100) between clock edges → outputs immediately read (799, 524), display_on = 0, frame_count = 255. Release rst_n and one enabled edge later → (0, 0).
